sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_reg.sv | 46 ++++
 rtl/sar_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sar_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared state type and default parameters for the SAR conversion controller.
package sar_pkg;

    // Controller phases: idle, input sampling, bit-by-bit conversion
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } sar_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NCH        = 4;
    localparam int DEF_SAMPLE_CYC = 2;

    // Sample-phase counter width; covers SAMPLE_CYC up to 15
    localparam int CNT_W = 4;

    // Channel index width, at least one bit even for a single channel
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sar_reg.sv
// sar_reg: successive-approximation register with a one-hot bit pointer.
// load clears the kept bits and points at the MSB; each trial resolves the
// pointed bit from cmp and moves the pointer one place towards the LSB.
module sar_reg
    import sar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             trial,
    input  logic             cmp,
    output logic [WIDTH-1:0] trial_code,
    output logic [WIDTH-1:0] result,
    output logic             last
);

    logic [WIDTH-1:0] kept;
    logic [WIDTH-1:0] ptr;

    // Kept bits and bit pointer: cleared on load, resolved one bit per trial
    always_ff @(posedge clk) begin
        if (rst) begin
            kept <= '0;
            ptr  <= '0;
        end else if (load) begin
            kept <= '0;
            ptr  <= {1'b1, {(WIDTH-1){1'b0}}};
        end else if (trial) begin
            if (cmp) begin
                kept <= kept | ptr;
            end
            ptr <= ptr >> 1;
        end
    end

    // Trial code is the kept bits plus the bit under test; the result folds
    // in the decision for the current bit so it is ready at the final edge
    always_comb begin
        trial_code = kept | ptr;
        result     = cmp ? (kept | ptr) : kept;
        last       = ptr[0];
    end

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: SAR ADC conversion controller (sample, then MSB-first binary
// search) with a channel mux and a valid/ready result port.
// Optional feature macro SAR_CONT_EN: when defined, start acts as a level
// enable and back-to-back conversions run on the latched channel.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NCH        = DEF_NCH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
    input  logic                                    cmp,
    output logic                                    samp,
    output logic [NCH-1:0]                          ch_mux,
    output logic [WIDTH-1:0]                        dac,
    output logic                                    busy,
    output logic [WIDTH-1:0]                        dout,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] dout_ch,
    output logic                                    dout_valid,
    input  logic                                    dout_ready,
    output logic                                    overrun
);

    localparam int CH_W = ch_width(NCH);

    sar_state_t       state;
    sar_state_t       next_state;
    logic [CNT_W-1:0] samp_cnt;
    logic [CH_W-1:0]  ch_lat;
    logic [CH_W-1:0]  ch_clamped;
    logic             ch_load;
    logic             sar_load;
    logic             sar_trial;
    logic             sar_last;
    logic             result_load;
    logic [WIDTH-1:0] trial_code;
    logic [WIDTH-1:0] result;

    sar_reg #(
        .WIDTH(WIDTH)
    ) u_sar_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (sar_load),
        .trial      (sar_trial),
        .cmp        (cmp),
        .trial_code (trial_code),
        .result     (result),
        .last       (sar_last)
    );

    // Out-of-range channel requests fall back to the highest channel
    always_comb begin
        ch_clamped = ch_sel;
        if (int'(ch_sel) >= NCH) begin
            ch_clamped = CH_W'(NCH - 1);
        end
    end

    // State register; reset overrides everything and abandons any conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and SAR control strobes
    always_comb begin
        next_state  = state;
        ch_load     = 1'b0;
        sar_load    = 1'b0;
        sar_trial   = 1'b0;
        result_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ch_load    = 1'b1;
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sar_load = 1'b1;
                if (samp_cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                    next_state = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                sar_trial = 1'b1;
                if (sar_last) begin
                    result_load = 1'b1;
`ifdef SAR_CONT_EN
                    next_state  = start ? ST_SAMPLE : ST_IDLE;
`else
                    next_state  = ST_IDLE;
`endif
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sample-phase cycle counter, idle at zero outside SAMPLE
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
        end else if (state == ST_SAMPLE) begin
            samp_cnt <= samp_cnt + CNT_W'(1);
        end else begin
            samp_cnt <= '0;
        end
    end

    // Channel latch, captured only when a conversion is accepted from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_lat <= '0;
        end else if (ch_load) begin
            ch_lat <= ch_clamped;
        end
    end

    // Analog-side outputs decoded from the current phase
    always_comb begin
        samp   = (state == ST_SAMPLE);
        busy   = (state != ST_IDLE);
        dac    = (state == ST_CONVERT) ? trial_code : '0;
        ch_mux = '0;
        if (state != ST_IDLE) begin
            ch_mux[ch_lat] = 1'b1;
        end
    end

    // Result port: load on conversion end, clear on handshake, flag overwrite
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (result_load) begin
                dout       <= result;
                dout_ch    <= ch_lat;
                dout_valid <= 1'b1;
                overrun    <= dout_valid && !dout_ready;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: self-checking bench for sar_ctrl (WIDTH=8, NCH=4, SAMPLE_CYC=2)
// with an ideal comparator and a binary-search reference for the trial codes.
module tb_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] ch_sel;
    logic       cmp;
    logic       samp;
    logic [3:0] ch_mux;
    logic [7:0] dac;
    logic       busy;
    logic [7:0] dout;
    logic [1:0] dout_ch;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;

    logic [7:0] vin_code;
    int         checks = 0;
    int         errors = 0;
    int         ovr_count = 0;

    sar_ctrl #(
        .WIDTH      (8),
        .NCH        (4),
        .SAMPLE_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_sel     (ch_sel),
        .cmp        (cmp),
        .samp       (samp),
        .ch_mux     (ch_mux),
        .dac        (dac),
        .busy       (busy),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Ideal comparator against the bench's analog input code
    assign cmp = (vin_code >= dac);

    // Count overrun pulses as seen just before each rising edge
    always @(posedge clk) begin
        if (overrun) ovr_count++;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] ch, input logic [7:0] vin);
        start    = s;
        ch_sel   = ch;
        vin_code = vin;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_samp"}, 32'(samp), 32'd0);
        checkOutput({tag, "_mux"}, 32'(ch_mux), 32'd0);
        checkOutput({tag, "_dac"}, 32'(dac), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
        checkOutput({tag, "_dout_ch"}, 32'(dout_ch), 32'd0);
        checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // One conversion started from IDLE; returns in the cycle the result appears.
    // fresh: result port must be empty before the load; ready_final: raise
    // dout_ready in the last trial cycle; poke: request start while busy.
    task automatic runConversion(input logic [7:0] vin, input logic [1:0] ch, input bit fresh,
                                 input bit ready_final, input bit exp_ovr, input bit poke);
        logic [3:0] exp_mux;
        logic [7:0] code;
        logic [7:0] trial;
        exp_mux = 4'b0001 << ch;
        code    = 8'h00;
        applyStimulus(1'b1, ch, vin);
        tick();
        applyStimulus(1'b0, ch, vin);
        for (int s = 0; s < 2; s++) begin
            checkOutput("samp_phase", 32'(samp), 32'd1);
            checkOutput("samp_dac", 32'(dac), 32'd0);
            checkOutput("samp_mux", 32'(ch_mux), 32'(exp_mux));
            checkOutput("samp_busy", 32'(busy), 32'd1);
            if (poke && s == 0) applyStimulus(1'b1, ~ch, vin);
            tick();
            applyStimulus(1'b0, ch, vin);
        end
        for (int k = 0; k < 8; k++) begin
            trial = code | (8'h80 >> k);
            checkOutput("conv_dac", 32'(dac), 32'(trial));
            checkOutput("conv_samp", 32'(samp), 32'd0);
            checkOutput("conv_mux", 32'(ch_mux), 32'(exp_mux));
            checkOutput("conv_busy", 32'(busy), 32'd1);
            if (fresh && k == 7) checkOutput("pre_valid", 32'(dout_valid), 32'd0);
            if (ready_final && k == 7) dout_ready = 1'b1;
            if (vin >= trial) code = trial;
            if (poke && k == 3) applyStimulus(1'b1, ~ch, vin);
            tick();
            applyStimulus(1'b0, ch, vin);
        end
        checkOutput("res_valid", 32'(dout_valid), 32'd1);
        checkOutput("res_dout", 32'(dout), 32'(vin));
        checkOutput("res_dout_ch", 32'(dout_ch), 32'(ch));
        checkOutput("res_overrun", 32'(overrun), 32'(exp_ovr));
        checkOutput("res_busy", 32'(busy), 32'd0);
        checkOutput("res_mux", 32'(ch_mux), 32'd0);
        checkOutput("res_dac", 32'(dac), 32'd0);
    endtask

    initial begin
        int         ovr0;
        logic [7:0] rv;
        logic [1:0] rc;

        // Reset state, and reset winning over start
        rst = 1'b1;
        dout_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00);
        tick();
        tick();
        checkAllZero("reset");
        applyStimulus(1'b1, 2'd2, 8'h00);
        tick();
        checkAllZero("reset_vs_start");
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00);
        tick();

        // Directed reference conversion and full-scale endpoints
        runConversion(8'hA5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("handshake_clear", 32'(dout_valid), 32'd0);
        runConversion(8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        runConversion(8'hFF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // Random codes and channels, some with ignored starts while busy
        for (int n = 0; n < 8; n++) begin
            rv = 8'($urandom_range(0, 255));
            rc = 2'($urandom_range(0, 3));
            runConversion(rv, rc, 1'b1, 1'b0, 1'b0, bit'(n % 2));
            tick();
            checkOutput("no_queue_busy", 32'(busy), 32'd0);
        end

        // Unconsumed result overwritten by the next one
        dout_ready = 1'b0;
        ovr0 = ovr_count;
        runConversion(8'h12, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("hold_valid", 32'(dout_valid), 32'd1);
        checkOutput("hold_dout", 32'(dout), 32'h12);
        runConversion(8'h34, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("ovr_single", 32'(overrun), 32'd0);
        checkOutput("ovr_valid", 32'(dout_valid), 32'd1);
        checkOutput("ovr_dout", 32'(dout), 32'h34);
        tick();
        checkOutput("ovr_count", 32'(ovr_count - ovr0), 32'd1);

        // Load coinciding with a handshake: new data, no overrun
        runConversion(8'h9C, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("same_cycle_clear", 32'(dout_valid), 32'd0);

        // Reset in the fourth CONVERT cycle, with start also asserted
        applyStimulus(1'b1, 2'd2, 8'h6C);
        tick();
        applyStimulus(1'b0, 2'd2, 8'h6C);
        for (int c = 0; c < 5; c++) tick();
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        checkOutput("pre_reset_samp", 32'(samp), 32'd0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        checkAllZero("mid_reset");
        rst = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        runConversion(8'h3E, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef SAR_CONT_EN
        // Level start: results every SAMPLE_CYC+WIDTH cycles until start drops
        applyStimulus(1'b1, 2'd1, 8'h5A);
        tick();
        for (int c = 1; c <= 42; c++) begin
            if (c == 33) start = 1'b0;
            checkOutput("cont_valid", 32'(dout_valid),
                        32'(c == 11 || c == 21 || c == 31 || c == 41));
            checkOutput("cont_busy", 32'(busy), 32'(c <= 40));
            if (c == 11 || c == 21 || c == 31 || c == 41) begin
                checkOutput("cont_dout", 32'(dout), 32'h5A);
                checkOutput("cont_dout_ch", 32'(dout_ch), 32'd1);
            end
            tick();
        end
`else
        // Held start: each conversion returns to IDLE before the next begins
        applyStimulus(1'b1, 2'd0, 8'h77);
        tick();
        for (int c = 1; c <= 22; c++) begin
            if (c == 12) start = 1'b0;
            checkOutput("held_busy", 32'(busy), 32'(c != 11 && c != 22));
            checkOutput("held_valid", 32'(dout_valid), 32'(c == 11 || c == 22));
            if (c == 11 || c == 22) checkOutput("held_dout", 32'(dout), 32'h77);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
